// File: rtl/rom_port_arbiter_if.sv
// Memory-side bus of the ROM port arbiter: one request/ack handshake that
// carries either a download write or a core program-fetch read.
interface rom_port_arbiter_if #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 8
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the game-ROM port between the HPS download stream (single-entry
// buffer, throttled by dl_wait) and williams2 reads; holds the core in reset until loaded.
module rom_port_arbiter #(
    parameter int unsigned   AW          = 18,
    parameter int unsigned   DW          = 8,
    parameter logic [AW-1:0] ROM_SIZE    = 18'h30000,
    parameter int unsigned   HOLD_CYCLES = 16
) (
    input  logic                clock_12,
    input  logic                reset_n,
    input  logic                dl_active,
    input  logic                dl_wr,
    input  logic [AW-1:0]       dl_addr,
    input  logic [DW-1:0]       dl_data,
    output logic                dl_wait,
    output logic                dl_overrun,
    output logic [AW:0]         dl_count,
    output logic                dl_done,
    input  logic                cpu_req,
    input  logic [AW-1:0]       cpu_addr,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_ack,
    output logic                core_reset,
    rom_port_arbiter_if.master  mem
);
    localparam int unsigned HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]    COUNT_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_ACK,
        S_HOLD
    } state_t;

    state_t         state, state_n;
    logic [AW-1:0]  buf_addr;
    logic [DW-1:0]  buf_data;
    logic           buf_valid;
    logic           dl_active_q;
    logic           seen_active;
    logic           rom_loaded;
    logic [HCW-1:0] hold_cnt;
    logic           mem_req_q;
    logic           mem_we_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;

    logic dl_rise;
    logic dl_finished;
    logic hold_term;
    logic wr_done;
    logic rd_done;

    assign dl_rise     = dl_active & ~dl_active_q;
    assign dl_finished = ~dl_active & seen_active & ~buf_valid;
    assign hold_term   = (state == S_HOLD) && (hold_cnt == HOLD_LAST);
    assign wr_done     = (state == S_WR) && mem.mem_ack;
    assign rd_done     = (state == S_RD) && mem.mem_ack;

    assign dl_wait       = buf_valid;
    assign cpu_ack       = (state == S_ACK);
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    // NOTE: every output of this block gets a default first, so no branch can infer a latch.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (buf_valid)
                    state_n = S_WR;
                else if (cpu_req && !core_reset && !cpu_ack)
                    state_n = S_RD;
                else if (!rom_loaded && dl_finished)
                    state_n = S_HOLD;
            end
            S_WR:   if (mem.mem_ack) state_n = S_IDLE;
            S_RD:   if (mem.mem_ack) state_n = S_ACK;
            S_ACK:  state_n = S_IDLE;
            S_HOLD: if (dl_rise || hold_term) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clock_12 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata   <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + HCW'(1) : '0;

            // Address/data are loaded only on entry so they stay frozen while mem_req is high.
            mem_req_q <= (state_n == S_WR) || (state_n == S_RD);
            mem_we_q  <= (state_n == S_WR);
            if (state == S_IDLE && state_n == S_WR) begin
                mem_addr_q  <= buf_addr;
                mem_wdata_q <= buf_data;
            end else if (state == S_IDLE && state_n == S_RD) begin
                mem_addr_q  <= cpu_addr;
            end

            if (rd_done)
                cpu_rdata <= mem.mem_rdata;
        end
    end

    // NOTE: the buffer entry is reset with everything else so mem_* never shows stale X after reset.
    always_ff @(posedge clock_12 or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            dl_overrun <= 1'b0;
            dl_count   <= '0;
        end else begin
            if (dl_wr) begin
                if (buf_valid) begin
                    dl_overrun <= 1'b1;
                end else if (dl_addr < ROM_SIZE) begin
                    buf_valid <= 1'b1;
                    buf_addr  <= dl_addr;
                    buf_data  <= dl_data;
                end
            end
            if (wr_done) begin
                buf_valid <= 1'b0;
                if (dl_count != COUNT_MAX)
                    dl_count <= dl_count + (AW+1)'(1);
            end
            // A new download restarts the statistics; placed last so it wins.
            if (dl_rise) begin
                dl_overrun <= 1'b0;
                dl_count   <= '0;
            end
        end
    end

    always_ff @(posedge clock_12 or negedge reset_n) begin
        if (!reset_n) begin
            dl_active_q <= 1'b0;
            seen_active <= 1'b0;
            rom_loaded  <= 1'b0;
            core_reset  <= 1'b1;
            dl_done     <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            dl_done     <= 1'b0;
            if (dl_active)
                seen_active <= 1'b1;
            if (dl_rise) begin
                core_reset <= 1'b1;
                rom_loaded <= 1'b0;
            end else if (hold_term) begin
                core_reset <= 1'b0;
                rom_loaded <= 1'b1;
                dl_done    <= 1'b1;
            end
        end
    end
endmodule
